// File: rtl/fp_add_sched_pkg.sv
// Shared types and FP32 field helpers for the shared-adder scheduler.
package fp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int CNT_W    = 4;

  // Sign is ignored: +0 and -0 both bypass the datapath.
  function automatic logic is_zero(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == '0) && (v[FRAC_MSB:0] == '0);
  endfunction

endpackage

// File: rtl/fp_add_sched_if.sv
// Requester, datapath and response signals of the scheduler bundled together.
interface fp_add_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               dp_start;
  logic [31:0]        dp_a;
  logic [31:0]        dp_b;
  logic [31:0]        dp_result;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_result;
  logic [IDW-1:0]     resp_id;

  modport slave (
    input  req_valid, req_a, req_b, dp_result, resp_ready,
    output req_ready, dp_start, dp_a, dp_b, resp_valid, resp_result, resp_id
  );

  modport master (
    output req_valid, req_a, req_b, dp_result, resp_ready,
    input  req_ready, dp_start, dp_a, dp_b, resp_valid, resp_result, resp_id
  );
endinterface

// File: rtl/fp_add_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request strictly after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (en && !found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_add_sched.sv
// Shares one fixed-latency FP32 adder among NREQ requesters, one operation in flight.
module fp_add_sched
  import fp_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DP_LAT = 3,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic           clk,
  input  logic           reset,
  fp_add_sched_if.slave  bus
);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [31:0]      dp_a_q, dp_a_d;
  logic [31:0]      dp_b_q, dp_b_d;
  logic [31:0]      resp_result_q, resp_result_d;
  logic             dp_start_q, dp_start_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             hs;
  logic [31:0]      op_a, op_b;
  logic [31:0]      a_arr [NREQ];
  logic [31:0]      b_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[gi*32 +: 32];
      assign b_arr[gi] = bus.req_b[gi*32 +: 32];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_q),
    .en     (state_q == IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // The arbiter only grants asserted requests, so any grant is a handshake.
  assign hs   = |gnt;
  assign op_a = a_arr[gnt_id];
  assign op_b = b_arr[gnt_id];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    resp_id_d     = resp_id_q;
    dp_a_d        = dp_a_q;
    dp_b_d        = dp_b_q;
    resp_result_d = resp_result_q;
    dp_start_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          dp_a_d    = op_a;
          dp_b_d    = op_b;
          resp_id_d = gnt_id;
          rr_ptr_d  = gnt_id;
          if (is_zero(op_a) || is_zero(op_b)) begin
            resp_result_d = is_zero(op_a) ? (is_zero(op_b) ? 32'h0000_0000 : op_b) : op_a;
            state_d       = RESP;
          end else begin
            dp_start_d = 1'b1;
            cnt_d      = CNT_W'(DP_LAT);
            state_d    = EXEC;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          resp_result_d = bus.dp_result;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rr_ptr_q      <= IDW'(NREQ - 1);
      resp_id_q     <= '0;
      dp_a_q        <= '0;
      dp_b_q        <= '0;
      resp_result_q <= '0;
      dp_start_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      resp_id_q     <= resp_id_d;
      dp_a_q        <= dp_a_d;
      dp_b_q        <= dp_b_d;
      resp_result_q <= resp_result_d;
      dp_start_q    <= dp_start_d;
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.dp_start    = dp_start_q;
  assign bus.dp_a        = dp_a_q;
  assign bus.dp_b        = dp_b_q;
  assign bus.resp_valid  = (state_q == RESP);
  assign bus.resp_result = resp_result_q;
  assign bus.resp_id     = resp_id_q;

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed bench for fp_add_sched with a small fixed-latency adder lookup model.
module tb_fp_add_sched;

  localparam int NREQ   = 4;
  localparam int DP_LAT = 3;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [1:0] vld_sh;

  fp_add_sched_if #(.NREQ(NREQ)) bus ();

  fp_add_sched #(
    .NREQ   (NREQ),
    .DP_LAT (DP_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known sums only; anything else yields a marker that no check expects.
  function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
    return 32'hBAD0_BAD0;
  endfunction

  // Sum is valid only in the cycle the scheduler captures it (DP_LAT=3).
  always @(posedge clk) begin
    vld_sh        <= {vld_sh[0], bus.dp_start};
    bus.dp_result <= vld_sh[0] ? dp_model(bus.dp_a, bus.dp_b) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat,
                       input int exp_pulses, input int hold, input bit keep);
    int w;
    int lat;
    int pulses;
    int stray;
    bus.req_a[idx*32 +: 32] = a;
    bus.req_b[idx*32 +: 32] = b;
    bus.req_valid[idx]      = 1'b1;
    #1;
    w = 0;
    while (bus.req_ready == '0 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("grant", 32'(bus.req_ready), 32'(1 << idx));
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid[idx] = 1'b0;
    lat = 0;
    pulses = 0;
    stray = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.dp_start) pulses++;
      if (bus.req_ready != '0) stray++;
      if (lat == 1) begin
        chk("dp_a", bus.dp_a, a);
        chk("dp_b", bus.dp_b, b);
      end
    end while (!bus.resp_valid && lat < 40);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("dp_start_pulses", 32'(pulses), 32'(exp_pulses));
    chk("busy_no_grant", 32'(stray), 32'd0);
    chk("resp_result", bus.resp_result, exp_res);
    chk("resp_id", 32'(bus.resp_id), 32'(idx));
    $display("op req=%0d a=%h b=%h res=%h id=%0d lat=%0d", idx, a, b,
             bus.resp_result, bus.resp_id, lat);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_data", bus.resp_result, exp_res);
      chk("hold_no_grant", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_clear", 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_dp_start", 32'(bus.dp_start), 32'd0);
    chk("rst_dp_a", bus.dp_a, 32'd0);
    chk("rst_dp_b", bus.dp_b, 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_result", bus.resp_result, 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);

    do_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, DP_LAT + 1, 1, 0, 1'b0);
    do_op(2, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, DP_LAT + 1, 1, 0, 1'b0);
    do_op(1, 32'h0000_0000, 32'h4120_0000, 32'h4120_0000, 1, 0, 0, 1'b0);
    do_op(3, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0, 0, 1'b0);
    do_op(2, 32'hC0A0_0000, 32'h8000_0000, 32'hC0A0_0000, 1, 0, 0, 1'b0);

    // Abort an operation mid-flight; the later datapath output must never surface.
    bus.req_a[3*32 +: 32] = 32'h3F80_0000;
    bus.req_b[3*32 +: 32] = 32'h4000_0000;
    bus.req_valid[3] = 1'b1;
    #1;
    chk("abort_grant", 32'(bus.req_ready), 32'h8);
    @(posedge clk);
    #1;
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    chk("abort_dp_start", 32'(bus.dp_start), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_dp_a", bus.dp_a, 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    begin
      int stale;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.resp_valid) stale++;
      end
      chk("abort_no_stale", 32'(stale), 32'd0);
    end

    // All requesters valid: grants rotate from 0 since the pointer was reset.
    for (int r = 0; r < NREQ; r++) begin
      bus.req_a[r*32 +: 32] = 32'h3F80_0000;
      bus.req_b[r*32 +: 32] = 32'h4000_0000;
    end
    bus.req_valid = '1;
    for (int k = 0; k < NREQ + 1; k++) begin
      do_op(k % NREQ, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, DP_LAT + 1, 1,
            (k == 0) ? 5 : 0, 1'b1);
    end
    bus.req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
